// File: rtl/feature_loader.sv
// feature_loader: serial-to-parallel front end for the fully-connected scoring layer.
// Collects N_FEAT DW-bit features, one per valid/ready beat, into a register
// frame and holds that frame stable for the combinational MAC layer until
// the consumer acknowledges it.
// Ports:
//   clk, rst       single clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_first   upstream beat stream (s_first = feature 0)
//   feat_bus       N_FEAT lanes, lane k = feat_bus[DW*k +: DW]
//   feat_valid     feat_bus holds a complete frame
//   feat_ready     consumer has sampled the frame
//   frame_err      one-cycle pulse when s_first arrives mid-frame
//   frame_cnt      frames handed off, wraps modulo 2^CW

// One feature register; written only on the beat that targets this lane.
module feature_lane #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst)     q <= '0;
        else if (we) q <= din;
    end
endmodule

module feature_loader #(
    parameter int N_FEAT = 22,
    parameter int DW     = 16,
    parameter int CW     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DW-1:0]        s_data,
    input  logic                 s_first,
    output logic [N_FEAT*DW-1:0] feat_bus,
    output logic                 feat_valid,
    input  logic                 feat_ready,
    output logic                 frame_err,
    output logic [CW-1:0]        frame_cnt
);
    localparam int IW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;

    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

    state_t                       state;
    logic   [IW-1:0]              idx;
    logic                         accept;
    logic                         resync;
    logic   [IW-1:0]              wr_idx;
    logic   [N_FEAT-1:0][DW-1:0]  lane_q;

    assign s_ready = (state == COLLECT) & ~rst;
    assign accept  = s_valid & s_ready;
    // s_first mid-frame restarts the frame: the beat becomes feature 0.
    assign resync  = accept & s_first & (idx != '0);
    assign wr_idx  = resync ? '0 : idx;

    for (genvar k = 0; k < N_FEAT; k++) begin : g_lane
        feature_lane #(.DW(DW)) u_lane (
            .clk (clk),
            .rst (rst),
            .we  (accept && (wr_idx == IW'(k))),
            .din (s_data),
            .q   (lane_q[k])
        );
    end

    // Packed lane array flattens with lane k at bits [DW*k +: DW].
    assign feat_bus = lane_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= COLLECT;
            idx        <= '0;
            feat_valid <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                COLLECT: begin
                    if (accept) begin
                        if (resync) begin
                            frame_err <= 1'b1;
                            idx       <= IW'(1);
                        end else if (idx == IW'(N_FEAT - 1)) begin
                            idx        <= '0;
                            state      <= HOLD;
                            feat_valid <= 1'b1;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (feat_ready) begin
                        feat_valid <= 1'b0;
                        state      <= COLLECT;
                        frame_cnt  <= frame_cnt + CW'(1);
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_feature_loader.sv
// Self-checking bench for feature_loader. A queue-based reference model
// tracks accepted beats, frame hand-off and the frame counter; every cycle
// the DUT outputs are compared against it, plus directed spot checks.
module tb_feature_loader;
    localparam int N  = 22;
    localparam int DW = 16;
    localparam int CW = 6;   // narrow counter so the wrap is reachable quickly
    localparam int BW = N * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_first;
    logic [BW-1:0] feat_bus;
    logic          feat_valid;
    logic          feat_ready;
    logic          frame_err;
    logic [CW-1:0] frame_cnt;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int            mq[$];
    bit            m_hold;
    bit            m_err;
    logic [CW-1:0] m_cnt;
    logic [BW-1:0] m_frame;

    feature_loader #(.N_FEAT(N), .DW(DW), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_first    (s_first),
        .feat_bus   (feat_bus),
        .feat_valid (feat_valid),
        .feat_ready (feat_ready),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check s_ready mid-cycle, advance model at the edge, check outputs after.
    task automatic step();
        @(negedge clk);
        chk("s_ready", BW'(s_ready), BW'(!rst && !m_hold));
        @(posedge clk);
        if (rst) begin
            mq = {};
            m_hold = 0; m_err = 0; m_cnt = '0; m_frame = '0;
        end else begin
            m_err = 0;
            if (!m_hold) begin
                if (s_valid) begin
                    if (s_first && mq.size() != 0) begin
                        m_err = 1;
                        mq = {};
                    end
                    mq.push_back(int'(s_data));
                    if (mq.size() == N) begin
                        for (int k = 0; k < N; k++) m_frame[k*DW +: DW] = DW'(mq[k]);
                        mq = {};
                        m_hold = 1;
                    end
                end
            end else if (feat_ready) begin
                m_hold = 0;
                m_cnt  = m_cnt + CW'(1);
            end
        end
        #1;
        chk("feat_valid", BW'(feat_valid), BW'(m_hold));
        chk("frame_err", BW'(frame_err), BW'(m_err));
        chk("frame_cnt", BW'(frame_cnt), BW'(m_cnt));
        if (m_hold) chk("feat_bus", feat_bus, m_frame);
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic f);
        s_valid = 1'b1; s_data = d; s_first = f;
        step();
    endtask

    initial begin
        logic [BW-1:0] exp_bus;
        logic [BW-1:0] held;
        int            start_cnt;
        int            guard;

        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_first = 1'b0; feat_ready = 1'b0;
        m_hold = 0; m_err = 0; m_cnt = '0; m_frame = '0;

        // reset
        step(); step();
        chk("rst_bus", feat_bus, '0);
        chk("rst_cnt", BW'(frame_cnt), '0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", BW'(s_ready), BW'(1));

        // nominal frame, data=k+1
        feat_ready = 1'b1;
        for (int k = 0; k < N; k++) beat(DW'(k + 1), k == 0);
        s_valid = 1'b0; s_first = 1'b0;
        for (int k = 0; k < N; k++) exp_bus[k*DW +: DW] = DW'(k + 1);
        chk("nom_valid", BW'(feat_valid), BW'(1));
        chk("nom_bus", feat_bus, exp_bus);
        step();
        chk("nom_valid_drop", BW'(feat_valid), '0);
        chk("nom_cnt", BW'(frame_cnt), BW'(1));

        // back-pressure
        feat_ready = 1'b0;
        for (int k = 0; k < N; k++) beat(DW'($urandom), k == 0);
        held = feat_bus;
        for (int c = 0; c < 10; c++) beat(16'hFFFF, 1'b0);
        chk("bp_bus_frozen", feat_bus, held);
        chk("bp_ready", BW'(s_ready), '0);
        feat_ready = 1'b1;
        beat(16'hFFFF, 1'b0);            // hand-off edge, beat refused
        feat_ready = 1'b0;
        beat(16'h1234, 1'b0);            // lands in lane 0
        chk("bp_lane0", BW'(feat_bus[DW-1:0]), BW'(16'h1234));
        for (int k = 1; k < N; k++) beat(DW'($urandom), 1'b0);
        chk("bp_frame_lane0", BW'(feat_bus[DW-1:0]), BW'(16'h1234));
        feat_ready = 1'b1;
        s_valid = 1'b0;
        step();

        // resync
        for (int k = 0; k < 5; k++) beat(DW'($urandom), k == 0);
        beat(16'hABCD, 1'b1);
        chk("rs_err", BW'(frame_err), BW'(1));
        chk("rs_lane0", BW'(feat_bus[DW-1:0]), BW'(16'hABCD));
        for (int k = 0; k < 20; k++) beat(DW'($urandom), 1'b0);
        chk("rs_not_done", BW'(feat_valid), '0);
        beat(DW'($urandom), 1'b0);
        chk("rs_done", BW'(feat_valid), BW'(1));
        chk("rs_frame_lane0", BW'(feat_bus[DW-1:0]), BW'(16'hABCD));
        s_valid = 1'b0;
        step();

        // bubbles over 3 frames with random ready
        start_cnt = int'(m_cnt);
        guard = 0;
        while (int'(m_cnt) != ((start_cnt + 3) % (1 << CW)) && guard < 1000) begin
            s_valid    = ($urandom_range(0, 2) != 0);
            s_data     = DW'($urandom);
            s_first    = (mq.size() == 0);
            feat_ready = ($urandom_range(0, 1) != 0);
            step();
            guard++;
        end
        chk("bubble_timeout", BW'(guard < 1000), BW'(1));
        chk("bubble_cnt", BW'(frame_cnt), BW'((start_cnt + 3) % (1 << CW)));

        // run frames until the counter wraps to zero
        s_valid = 1'b0; feat_ready = 1'b1;
        if (m_hold) step();
        guard = 0;
        while (m_cnt != '0 && guard < 100) begin
            for (int k = 0; k < N; k++) beat(DW'($urandom), k == 0);
            s_valid = 1'b0;
            step();
            guard++;
        end
        chk("wrap_cnt", BW'(frame_cnt), '0);
        chk("wrap_guard", BW'(guard < 100), BW'(1));

        // reset mid-frame
        for (int k = 0; k < 10; k++) beat(DW'($urandom), k == 0);
        rst = 1'b1;
        beat(16'h5555, 1'b0);
        chk("midrst_bus", feat_bus, '0);
        rst = 1'b0;
        beat(16'h0BEE, 1'b0);
        chk("midrst_lane0", BW'(feat_bus[DW-1:0]), BW'(16'h0BEE));
        for (int k = 1; k < N; k++) beat(DW'($urandom), 1'b0);
        chk("midrst_valid", BW'(feat_valid), BW'(1));
        chk("midrst_cnt", BW'(frame_cnt), '0);
        s_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
